rename_history_buffer: RTL and testbench
========================================

// Module: rename_history_buffer
// PURPOSE
//  Circular history of superseded rename mappings, indexed by SqN. Each issued uop writes its
//  arch reg and the tag it overwrote. Commit frees entries from the head. On flush, a walk FSM
//  replays squashed entries newest-first so the RAT can restore its mappings.
//  Sits beside the rename stage. Read-by-SqN is replaced by occupancy tracking and rollback walk.
// PARAMETERS
//  NUM_UOPS     3   issue lanes and rollback outputs per cycle
//  NUM_ENTRIES  32  buffer depth; power of two, >= 2*NUM_UOPS
//  SQN_W        6   SqN width; must equal $clog2(NUM_ENTRIES)+1 (extra wrap bit)
//  NM_W         6   architectural register number width
//  TAG_W        7   physical tag width
// PORTS
//  clk            in   1               clock
//  rst            in   1               asynchronous reset, active-high
//  IN_issueValid  in   NUM_UOPS        lane write enable; valid lanes contiguous from lane 0
//  IN_issueSqNs   in   NUM_UOPS*SQN_W  per-lane SqN; lane k must equal tail+k
//  IN_issueRegNms in   NUM_UOPS*NM_W   per-lane destination arch reg
//  IN_issueTags   in   NUM_UOPS*TAG_W  per-lane previous (overwritten) tag
//  IN_commitValid in   1               retire update
//  IN_commitSqN   in   SQN_W           oldest un-retired SqN after this commit (new head)
//  IN_flushValid  in   1               squash request
//  IN_flushSqN    in   SQN_W           first squashed SqN; all SqN >= this are undone
//  OUT_rbValid    out  NUM_UOPS        rollback lane valid, lane 0 = newest
//  OUT_rbRegNm    out  NUM_UOPS*NM_W   rollback arch reg
//  OUT_rbTag      out  NUM_UOPS*TAG_W  tag to restore
//  OUT_busy       out  1               walk active; rename must stall
//  OUT_full       out  1               free slots < NUM_UOPS
//  OUT_count      out  SQN_W           occupancy (tail-head)
// BEHAVIOUR
//  - Reset (async): head=tail=0, all entry valid bits 0, FSM IDLE, OUT_rbValid=0, OUT_busy=0,
//    OUT_full=0, OUT_count=0. Entry payload not reset. Reset mid-walk aborts the walk.
//  - Index = SqN[SQN_W-2:0]. Ordering is modular: a older than b iff $signed(a-b)<0.
//  - Issue (IDLE only): valid lanes write {RegNm,Tag}, set valid bit; tail += popcount(valid).
//    Issue while OUT_busy or OUT_full is ignored; it is flagged by a simulation assertion.
//  - Commit: head <= IN_commitSqN; valid bits in [old head, new head) cleared the same cycle.
//    Commit must not pass tail (asserted). Commit is honoured in IDLE and WALK.
//  - OUT_full and OUT_count are combinational from head/tail: full iff NUM_ENTRIES-count < NUM_UOPS.
//  - Flush in IDLE: stop<=max(IN_flushSqN, head) under modular ordering; walkPtr<=tail-1.
//    If stop==tail: no walk, FSM stays IDLE, OUT_busy stays 0. Otherwise FSM goes to WALK.
//  - WALK, per cycle: lane k checks walkPtr-k. Valid iff that SqN >= stop and its entry valid
//    bit is 1. OUT_rb* are registered and appear the cycle after the entry is examined. Walked
//    entries have their valid bit cleared. walkPtr -= NUM_UOPS.
//    When the next walkPtr would be older than stop: tail<=stop, FSM goes to IDLE.
//    OUT_busy falls in the same cycle the last OUT_rbValid is presented.
//  - First rollback output comes 1 cycle after flush. N squashed entries need
//    ceil(N/NUM_UOPS) output cycles.
//  - Flush during WALK: if the new SqN is older than stop, stop is lowered and the walk continues
//    from the current walkPtr. A younger or equal flush SqN is ignored.
//  - Simultaneous issue+flush in IDLE: flush wins and the issue is dropped.
//    Simultaneous commit+flush: both apply, commit first.
//  - Wrap: pointers wrap modulo 2^SQN_W. Full and empty are distinguished by the wrap bit.
// STRUCTURE
//  - Shared package: SqN_t, RegNm_t, Tag_t typedefs, and the entry struct {valid, RegNm, Tag}.
//  - Walk FSM (IDLE/WALK) and stop/walkPtr logic sit in one sub-module:
//    rename_history_walker. Storage, pointers and commit logic are in the top module.
// TESTING
//  1 reset -> count=0, full=0, busy=0, rbValid=0; assert rst mid-walk -> all outputs 0 next edge.
//  2 issue SqN 0..2 (r1/t10,r2/t11,r3/t12), flush SqN 0 -> next cycle rbValid=111,
//    lanes = r3/t12, r2/t11, r1/t10; busy 1 cycle; count=0.
//  3 fill to 30 entries -> full=1; commit head to 5 -> count=25, full=0.
//  4 head=28, issue SqN 28..36 (wrap), flush 30 -> 7 entries over 3 cycles (3,3,1), newest
//    first; tail=30.
//  5 walk of flush 20 from tail 32, flush 15 in 2nd walk cycle -> walk extends to 15, tail=15.
//  6 flush SqN == tail -> busy stays 0, no rbValid. Issue+flush same cycle -> issue dropped.

Source files
------------

// File: rtl/rename_history_buffer_pkg.sv
// Shared types, sizes and SqN ordering helpers for the rename history buffer.
// Pure declarations: no latency or flow control of its own.
package rename_history_buffer_pkg;
    localparam int NUM_UOPS    = 3;
    localparam int NUM_ENTRIES = 32;
    localparam int SQN_W       = 6;
    localparam int NM_W        = 6;
    localparam int TAG_W       = 7;
    localparam int IDX_W       = SQN_W - 1;

    typedef logic [SQN_W-1:0] SqN_t;
    typedef logic [NM_W-1:0]  RegNm_t;
    typedef logic [TAG_W-1:0] Tag_t;

    typedef struct packed {
        logic   valid;
        RegNm_t reg_nm;
        Tag_t   tag;
    } entry_t;

    typedef enum logic {IDLE, WALK} walk_state_t;

    // a is older than b when the wrapped difference is negative
    function automatic logic sqn_older(input SqN_t a, input SqN_t b);
        SqN_t d;
        d = a - b;
        return d[SQN_W-1];
    endfunction

    function automatic SqN_t sqn_max(input SqN_t a, input SqN_t b);
        return sqn_older(a, b) ? b : a;
    endfunction

    function automatic SqN_t popcount(input logic [NUM_UOPS-1:0] v);
        SqN_t n;
        n = '0;
        for (int k = 0; k < NUM_UOPS; k++) n = n + SqN_t'(v[k]);
        return n;
    endfunction
endpackage

// File: rtl/rename_history_buffer_if.sv
// Rename-side bundle: issue/commit/flush requests in, rollback lanes and occupancy out.
// Wires only; rename stalls on busy/full rather than a per-lane ready.
interface rename_history_buffer_if;
    import rename_history_buffer_pkg::*;

    logic [NUM_UOPS-1:0]   issue_vld;
    SqN_t [NUM_UOPS-1:0]   issue_sqn;
    RegNm_t [NUM_UOPS-1:0] issue_reg_nm;
    Tag_t [NUM_UOPS-1:0]   issue_tag;
    logic                  commit_vld;
    SqN_t                  commit_sqn;
    logic                  flush_vld;
    SqN_t                  flush_sqn;
    logic [NUM_UOPS-1:0]   rb_vld;
    RegNm_t [NUM_UOPS-1:0] rb_reg_nm;
    Tag_t [NUM_UOPS-1:0]   rb_tag;
    logic                  busy;
    logic                  full;
    SqN_t                  count;

    modport master (
        output issue_vld, issue_sqn, issue_reg_nm, issue_tag,
        output commit_vld, commit_sqn, flush_vld, flush_sqn,
        input  rb_vld, rb_reg_nm, rb_tag, busy, full, count
    );

    modport slave (
        input  issue_vld, issue_sqn, issue_reg_nm, issue_tag,
        input  commit_vld, commit_sqn, flush_vld, flush_sqn,
        output rb_vld, rb_reg_nm, rb_tag, busy, full, count
    );
endinterface

// File: rtl/rename_history_walker.sv
// Rollback walk FSM: replays squashed entries newest-first, NUM_UOPS per cycle, one cycle after
// examination; busy holds rename off for the whole walk and drops with the last rollback beat.
module rename_history_walker
    import rename_history_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_vld,
    input  SqN_t                  flush_sqn,
    input  SqN_t                  head_nxt,
    input  SqN_t                  tail,
    input  entry_t                entries [NUM_ENTRIES],
    output logic                  busy,
    output logic                  tail_load,
    output SqN_t                  tail_val,
    output logic [NUM_ENTRIES-1:0] clr,
    output logic [NUM_UOPS-1:0]   rb_vld,
    output RegNm_t [NUM_UOPS-1:0] rb_reg_nm,
    output Tag_t [NUM_UOPS-1:0]   rb_tag
);
    walk_state_t         state;
    SqN_t                stop;
    SqN_t                walk_ptr;
    SqN_t                stop_req;
    SqN_t                stop_eff;
    SqN_t                ptr_nxt;
    logic                start_walk;
    logic                lower;
    logic                done;
    SqN_t                lane_sqn [NUM_UOPS];
    entry_t              lane_ent [NUM_UOPS];
    logic [NUM_UOPS-1:0] take;
    logic [NUM_UOPS-1:0] lane_vld;

    // Committed entries can never be undone, so the stop point is clamped to the new head.
    assign stop_req   = sqn_max(flush_sqn, head_nxt);
    assign start_walk = (state == IDLE) && flush_vld && sqn_older(stop_req, tail);
    assign lower      = (state == WALK) && flush_vld && sqn_older(flush_sqn, stop);
    assign stop_eff   = lower ? stop_req : stop;
    assign ptr_nxt    = walk_ptr - SqN_t'(NUM_UOPS);
    assign done       = (state == WALK) && sqn_older(ptr_nxt, stop_eff);
    assign tail_load  = done;
    assign tail_val   = stop_eff;

    always_comb begin
        clr      = '0;
        take     = '0;
        lane_vld = '0;
        for (int k = 0; k < NUM_UOPS; k++) begin
            lane_sqn[k] = walk_ptr - SqN_t'(k);
            lane_ent[k] = entries[lane_sqn[k][IDX_W-1:0]];
            take[k]     = (state == WALK) && !sqn_older(lane_sqn[k], stop_eff);
            lane_vld[k] = take[k] && lane_ent[k].valid;
            if (take[k]) clr[lane_sqn[k][IDX_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop      <= '0;
            walk_ptr  <= '0;
            rb_vld    <= '0;
            rb_reg_nm <= '0;
            rb_tag    <= '0;
        end else begin
            rb_vld <= lane_vld;
            for (int k = 0; k < NUM_UOPS; k++) begin
                rb_reg_nm[k] <= lane_vld[k] ? lane_ent[k].reg_nm : '0;
                rb_tag[k]    <= lane_vld[k] ? lane_ent[k].tag    : '0;
            end
            case (state)
                IDLE: begin
                    if (start_walk) begin
                        state    <= WALK;
                        busy     <= 1'b1;
                        stop     <= stop_req;
                        walk_ptr <= tail - SqN_t'(1);
                    end
                end
                WALK: begin
                    stop <= stop_eff;
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        walk_ptr <= ptr_nxt;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/rename_history_buffer.sv
// Circular SqN-indexed history of overwritten rename mappings with commit and rollback walk.
// Issue writes land next cycle; issue is dropped while busy/full or on a same-cycle flush.
module rename_history_buffer
    import rename_history_buffer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    rename_history_buffer_if.slave bus
);
    SqN_t                   head;
    SqN_t                   tail;
    SqN_t                   head_nxt;
    SqN_t                   count;
    logic                   full;
    logic                   busy;
    logic                   issue_ok;
    logic                   tail_load;
    SqN_t                   tail_val;
    logic [NUM_ENTRIES-1:0] vld_q;
    logic [NUM_ENTRIES-1:0] vld_nxt;
    logic [NUM_ENTRIES-1:0] commit_clr;
    logic [NUM_ENTRIES-1:0] walk_clr;
    RegNm_t                 reg_q [NUM_ENTRIES];
    Tag_t                   tag_q [NUM_ENTRIES];
    entry_t                 entries [NUM_ENTRIES];

    assign head_nxt = bus.commit_vld ? bus.commit_sqn : head;
    assign count    = tail - head;
    assign full     = (SqN_t'(NUM_ENTRIES) - count) < SqN_t'(NUM_UOPS);
    assign issue_ok = !busy && !full && !bus.flush_vld;

    assign bus.count = count;
    assign bus.full  = full;
    assign bus.busy  = busy;

    always_comb begin
        commit_clr = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            commit_clr[i] = {1'b0, IDX_W'(i) - head[IDX_W-1:0]} < (head_nxt - head);
    end

    always_comb begin
        vld_nxt = vld_q & ~commit_clr & ~walk_clr;
        for (int k = 0; k < NUM_UOPS; k++)
            if (issue_ok && bus.issue_vld[k]) vld_nxt[bus.issue_sqn[k][IDX_W-1:0]] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++)
            entries[i] = {vld_q[i], reg_q[i], tag_q[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            vld_q <= vld_nxt;
            head  <= head_nxt;
            if (tail_load)     tail <= tail_val;
            else if (issue_ok) tail <= tail + popcount(bus.issue_vld);
        end
    end

    // Payload is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_UOPS; k++) begin
            if (issue_ok && bus.issue_vld[k]) begin
                reg_q[bus.issue_sqn[k][IDX_W-1:0]] <= bus.issue_reg_nm[k];
                tag_q[bus.issue_sqn[k][IDX_W-1:0]] <= bus.issue_tag[k];
            end
        end
    end

    rename_history_walker u_walker (
        .clk       (clk),
        .rst       (rst),
        .flush_vld (bus.flush_vld),
        .flush_sqn (bus.flush_sqn),
        .head_nxt  (head_nxt),
        .tail      (tail),
        .entries   (entries),
        .busy      (busy),
        .tail_load (tail_load),
        .tail_val  (tail_val),
        .clr       (walk_clr),
        .rb_vld    (bus.rb_vld),
        .rb_reg_nm (bus.rb_reg_nm),
        .rb_tag    (bus.rb_tag)
    );

    a_issue_blocked: assert property (@(posedge clk) disable iff (rst)
        !((|bus.issue_vld) && (busy || full)));
    a_commit_past_tail: assert property (@(posedge clk) disable iff (rst)
        !(bus.commit_vld && sqn_older(tail, bus.commit_sqn)));
    a_issue_sqn: assert property (@(posedge clk) disable iff (rst)
        !(issue_ok && bus.issue_vld[0] && (bus.issue_sqn[0] != tail)));
endmodule

// File: tb/tb_rename_history_buffer.sv
// Directed plus randomized bench for rename_history_buffer against an absolute-SqN queue model.
module tb_rename_history_buffer;
    import rename_history_buffer_pkg::*;

    typedef struct {
        int          sqn;
        logic [5:0]  nm;
        logic [6:0]  tag;
    } ment_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   m_head = 0;
    int   m_tail = 0;
    ment_t q[$];

    rename_history_buffer_if bus();

    rename_history_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_occ(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'(m_tail - m_head));
        chk({tag, "_full"}, 32'(bus.full), 32'((32 - (m_tail - m_head)) < 3));
    endtask

    task automatic do_issue(input int n, input bit fixed, input int nm0, input int tg0);
        ment_t e;
        for (int k = 0; k < 3; k++) begin
            e.sqn = m_tail + k;
            e.nm  = fixed ? 6'(nm0 + k) : 6'($urandom_range(0, 63));
            e.tag = fixed ? 7'(tg0 + k) : 7'($urandom_range(0, 127));
            bus.issue_vld[k]    = (k < n);
            bus.issue_sqn[k]    = SqN_t'(e.sqn & 63);
            bus.issue_reg_nm[k] = e.nm;
            bus.issue_tag[k]    = e.tag;
            if (k < n) q.push_back(e);
        end
        m_tail += n;
        tick();
        bus.issue_vld = '0;
        chk_occ("issue");
    endtask

    task automatic do_commit(input int nh);
        bus.commit_vld = 1'b1;
        bus.commit_sqn = SqN_t'(nh & 63);
        tick();
        bus.commit_vld = 1'b0;
        while (q.size() > 0 && q[0].sqn < nh) void'(q.pop_front());
        m_head = nh;
        chk_occ("commit");
    endtask

    // Rollback stream is every live entry at or above the final stop, newest first, 3 per beat.
    task automatic do_flush(input int fsqn, input int lower, input int lower_at);
        ment_t exp_q[$];
        int    stop;
        int    n;
        int    nch;
        int    idx;
        stop = (fsqn > m_head) ? fsqn : m_head;
        if (lower_at > 0 && lower < stop) stop = (lower > m_head) ? lower : m_head;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].sqn < stop) break;
            exp_q.push_back(q[i]);
        end
        n   = exp_q.size();
        nch = (n + 2) / 3;
        bus.flush_vld = 1'b1;
        bus.flush_sqn = SqN_t'(fsqn & 63);
        tick();
        bus.flush_vld = 1'b0;
        chk("busy_start", 32'(bus.busy), 32'(n > 0));
        for (int k = 1; k <= nch; k++) begin
            if (k == lower_at) begin
                bus.flush_vld = 1'b1;
                bus.flush_sqn = SqN_t'(lower & 63);
            end
            tick();
            bus.flush_vld = 1'b0;
            for (int j = 0; j < 3; j++) begin
                idx = (k - 1) * 3 + j;
                chk($sformatf("rb_vld[%0d]", j), 32'(bus.rb_vld[j]), 32'(idx < n));
                if (idx < n) begin
                    chk($sformatf("rb_nm[%0d]", j), 32'(bus.rb_reg_nm[j]), 32'(exp_q[idx].nm));
                    chk($sformatf("rb_tag[%0d]", j), 32'(bus.rb_tag[j]), 32'(exp_q[idx].tag));
                end
            end
            chk("busy_walk", 32'(bus.busy), 32'(k < nch));
        end
        tick();
        chk("rb_after", 32'(bus.rb_vld), 32'd0);
        repeat (n) void'(q.pop_back());
        if (n > 0) m_tail = stop;
        chk_occ("flush");
    endtask

    initial begin
        int cnt;
        bus.issue_vld    = '0;
        bus.issue_sqn    = '0;
        bus.issue_reg_nm = '0;
        bus.issue_tag    = '0;
        bus.commit_vld   = 1'b0;
        bus.commit_sqn   = '0;
        bus.flush_vld    = 1'b0;
        bus.flush_sqn    = '0;

        // reset state
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rb", 32'(bus.rb_vld), 32'd0);
        rst = 1'b0;
        tick();

        // three-entry rollback in one beat
        do_issue(3, 1'b1, 1, 10);
        do_flush(0, 0, 0);

        // fill to 30 then commit to 5
        for (int i = 0; i < 10; i++) do_issue(3, 1'b0, 0, 0);
        chk("fill_full", 32'(bus.full), 32'd1);
        do_commit(5);

        // wrap-around walk from head 28
        do_commit(28);
        do_flush(28, 0, 0);
        for (int i = 0; i < 3; i++) do_issue(3, 1'b0, 0, 0);
        do_flush(30, 0, 0);

        // flush at tail, then issue dropped by same-cycle flush
        do_flush(m_tail, 0, 0);
        for (int k = 0; k < 3; k++) begin
            bus.issue_vld[k]    = 1'b1;
            bus.issue_sqn[k]    = SqN_t'((m_tail + k) & 63);
            bus.issue_reg_nm[k] = 6'($urandom_range(0, 63));
            bus.issue_tag[k]    = 7'($urandom_range(0, 127));
        end
        bus.flush_vld = 1'b1;
        bus.flush_sqn = SqN_t'(m_tail & 63);
        tick();
        bus.issue_vld = '0;
        bus.flush_vld = 1'b0;
        chk_occ("drop");
        chk("drop_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("drop_rb", 32'(bus.rb_vld), 32'd0);

        // reset in the middle of a walk
        do_issue(3, 1'b0, 0, 0);
        do_issue(3, 1'b0, 0, 0);
        bus.flush_vld = 1'b1;
        bus.flush_sqn = SqN_t'(28);
        tick();
        bus.flush_vld = 1'b0;
        chk("mw_busy", 32'(bus.busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("mw_busy_rst", 32'(bus.busy), 32'd0);
        chk("mw_rb_rst", 32'(bus.rb_vld), 32'd0);
        chk("mw_count_rst", 32'(bus.count), 32'd0);
        chk("mw_full_rst", 32'(bus.full), 32'd0);
        rst = 1'b0;
        q.delete();
        m_head = 0;
        m_tail = 0;
        tick();

        // walk lowered mid-flight: flush 20 from tail 32, flush 15 in second walk cycle
        for (int i = 0; i < 10; i++) do_issue(3, 1'b0, 0, 0);
        do_commit(10);
        do_issue(2, 1'b0, 0, 0);
        do_flush(20, 15, 2);

        // randomized mix
        for (int it = 0; it < 150; it++) begin
            cnt = m_tail - m_head;
            case ($urandom_range(0, 3))
                0, 1: begin
                    if (cnt <= 29) do_issue(int'($urandom_range(1, 3)), 1'b0, 0, 0);
                    else do_commit(m_head + int'($urandom_range(1, cnt)));
                end
                2: do_commit(m_head + int'($urandom_range(0, cnt)));
                default: do_flush(m_head - int'($urandom_range(0, 2)) + int'($urandom_range(0, cnt)), 0, 0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
